// File: rtl/phy_mem_ctrl_pkg.sv
// Shared types and constants for the physical SRAM controller.
// Holds the main/drain state encodings, the SRAM strobe bundle and the
// value returned for reads that fall outside the populated SRAM window.
package phy_mem_ctrl_pkg;

    // Main request FSM: accept in IDLE, wait on the SRAM in RD_ACC, hand back in DONE
    typedef enum logic [1:0] {
        MAIN_IDLE   = 2'd0,
        MAIN_RD_ACC = 2'd1,
        MAIN_DONE   = 2'd2
    } main_state_t;

    // Write-buffer drain FSM: address/data setup, we_n pulse, data hold
    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_SETUP = 2'd1,
        D_PULSE = 2'd2,
        D_HOLD  = 2'd3
    } drain_state_t;

    // Data handed to the initiator for a read outside the SRAM window
    localparam logic [31:0] OUT_OF_RANGE_RDATA = 32'h0000_0000;

    // SRAM control pins grouped so the pin mux can pick one bundle per owner
    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic dq_oe;
    } sram_strobe_t;

    localparam sram_strobe_t STROBE_IDLE     = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0};
    localparam sram_strobe_t STROBE_READ     = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, dq_oe: 1'b0};
    localparam sram_strobe_t STROBE_WR_SETUP = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b1};
    localparam sram_strobe_t STROBE_WR_PULSE = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0, dq_oe: 1'b1};

    // True when a byte address has any bit set above the SRAM word-address field
    function automatic logic addr_out_of_range(input logic [31:0] byte_addr, input int addr_w);
        logic [31:0] upper;
        if (addr_w + 2 >= 32) begin
            upper = 32'd0;
        end else begin
            upper = byte_addr >> (addr_w + 2);
        end
        return (upper != 32'd0);
    endfunction

endpackage

// File: rtl/phy_mem_wbuf.sv
// One-entry posted write buffer for the SRAM controller.
// Holds a single {word address, data} pair, offers a hit compare so reads can
// be forwarded from it, and drains it to the SRAM with a setup / we_n pulse /
// hold sequence. While draining it owns the SRAM pins.
module phy_mem_wbuf
    import phy_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 20,
    parameter int WR_PULSE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              buf_valid,
    output logic              buf_hit,
    output logic [31:0]       buf_data,
    output logic              drain_active,
    output logic [ADDR_W-1:0] drain_addr,
    output logic [31:0]       drain_data,
    output sram_strobe_t      drain_strobe
);

    // Pulse counter runs WR_PULSE-1 down to 0 while we_n is low
    localparam int PULSE_CNT_W = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
    localparam logic [PULSE_CNT_W-1:0] PULSE_START = PULSE_CNT_W'(WR_PULSE - 1);

    logic [ADDR_W-1:0]      buf_addr;
    logic [PULSE_CNT_W-1:0] pulse_cnt;
    drain_state_t           d_state;
    drain_state_t           d_next;

    // Buffer entry: filled by a posted write, released when the drain finishes its hold cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else if (load) begin
            buf_valid <= 1'b1;
            buf_addr  <= load_addr;
            buf_data  <= load_data;
        end else if (d_state == D_HOLD) begin
            buf_valid <= 1'b0;
        end
    end

    // Drain state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_state <= D_IDLE;
        end else begin
            d_state <= d_next;
        end
    end

    // Drain next state: start whenever an entry is waiting, one cycle each for setup and hold
    always_comb begin
        d_next = d_state;
        case (d_state)
            D_IDLE:  if (buf_valid) d_next = D_SETUP;
            D_SETUP: d_next = D_PULSE;
            D_PULSE: if (pulse_cnt == '0) d_next = D_HOLD;
            D_HOLD:  d_next = D_IDLE;
            default: d_next = D_IDLE;
        endcase
    end

    // Pulse-width counter, armed during setup and counted down while we_n is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pulse_cnt <= '0;
        end else if (d_state == D_SETUP) begin
            pulse_cnt <= PULSE_START;
        end else if (d_state == D_PULSE && pulse_cnt != '0) begin
            pulse_cnt <= pulse_cnt - 1'b1;
        end
    end

    // Drain outputs: strobes per phase, pins claimed for the whole setup..hold window
    always_comb begin
        drain_active = 1'b0;
        drain_strobe = STROBE_IDLE;
        case (d_state)
            D_SETUP: begin
                drain_active = 1'b1;
                drain_strobe = STROBE_WR_SETUP;
            end
            D_PULSE: begin
                drain_active = 1'b1;
                drain_strobe = STROBE_WR_PULSE;
            end
            D_HOLD: begin
                drain_active = 1'b1;
                drain_strobe = STROBE_WR_SETUP;
            end
            default: begin
                drain_active = 1'b0;
                drain_strobe = STROBE_IDLE;
            end
        endcase
    end

    assign buf_hit    = buf_valid && (buf_addr == lookup_addr);
    assign drain_addr = buf_addr;
    assign drain_data = buf_data;

endmodule

// File: rtl/phy_mem_ctrl.sv
// Physical memory controller: responder end of the CPU dev_mem_* interface.
// Writes are posted into a one-entry buffer and drained in the background;
// reads are forwarded from the buffer on a word-address hit, otherwise wait
// for the buffer to empty and then run an oe_n access of RD_WAIT+1 cycles.
// Addresses above the SRAM window complete at once (reads return zero,
// writes are dropped). Pad tri-stating is left to the board top.
// Note: the reset input 'rst' is active-low and asynchronous.
module phy_mem_ctrl
    import phy_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 20,
    parameter int RD_WAIT  = 1,
    parameter int WR_PULSE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dev_mem_addr,
    input  logic [31:0]       dev_mem_data_out,
    input  logic              dev_mem_is_write,
    output logic [31:0]       dev_mem_data_in,
    output logic              dev_mem_busy,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [31:0]       sram_dq_in,
    output logic [31:0]       sram_dq_out,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int RD_CNT_W = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;
    localparam logic [RD_CNT_W-1:0] RD_START = RD_CNT_W'(RD_WAIT);

    main_state_t         state;
    main_state_t         state_next;
    logic [RD_CNT_W-1:0] rd_cnt;

    logic [ADDR_W-1:0]   req_word;
    logic                req_oor;
    logic                addr_lsb_unused;

    logic                buf_valid;
    logic                buf_hit;
    logic [31:0]         buf_data;
    logic                drain_active;
    logic [ADDR_W-1:0]   drain_addr;
    logic [31:0]         drain_data;
    sram_strobe_t        drain_strobe;

    logic                buf_load;
    logic                rd_cnt_load;
    logic                rdata_load;
    logic [31:0]         rdata_next;
    sram_strobe_t        pin_strobe;

    assign req_word        = dev_mem_addr[ADDR_W+1:2];
    assign req_oor         = addr_out_of_range(dev_mem_addr, ADDR_W);
    assign addr_lsb_unused = ^dev_mem_addr[1:0];

    phy_mem_wbuf #(
        .ADDR_W   (ADDR_W),
        .WR_PULSE (WR_PULSE)
    ) u_wbuf (
        .clk          (clk),
        .rst          (rst),
        .load         (buf_load),
        .load_addr    (req_word),
        .load_data    (dev_mem_data_out),
        .lookup_addr  (req_word),
        .buf_valid    (buf_valid),
        .buf_hit      (buf_hit),
        .buf_data     (buf_data),
        .drain_active (drain_active),
        .drain_addr   (drain_addr),
        .drain_data   (drain_data),
        .drain_strobe (drain_strobe)
    );

    // Main state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MAIN_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Main next state: decide how the request sampled in IDLE is served
    always_comb begin
        state_next = state;
        case (state)
            MAIN_IDLE: begin
                if (req_oor) begin
                    state_next = MAIN_DONE;
                end else if (dev_mem_is_write) begin
                    if (!buf_valid) state_next = MAIN_DONE;
                end else if (buf_valid) begin
                    if (buf_hit) state_next = MAIN_DONE;
                end else begin
                    state_next = MAIN_RD_ACC;
                end
            end
            MAIN_RD_ACC: if (rd_cnt == '0) state_next = MAIN_DONE;
            MAIN_DONE:   state_next = MAIN_IDLE;
            default:     state_next = MAIN_IDLE;
        endcase
    end

    // Main outputs: buffer load, read counter arm and the value to latch as read data
    always_comb begin
        buf_load    = 1'b0;
        rd_cnt_load = 1'b0;
        rdata_load  = 1'b0;
        rdata_next  = dev_mem_data_in;
        case (state)
            MAIN_IDLE: begin
                if (req_oor) begin
                    if (!dev_mem_is_write) begin
                        rdata_load = 1'b1;
                        rdata_next = OUT_OF_RANGE_RDATA;
                    end
                end else if (dev_mem_is_write) begin
                    buf_load = !buf_valid;
                end else if (buf_valid) begin
                    if (buf_hit) begin
                        rdata_load = 1'b1;
                        rdata_next = buf_data;
                    end
                end else begin
                    rd_cnt_load = 1'b1;
                end
            end
            MAIN_RD_ACC: begin
                if (rd_cnt == '0) begin
                    rdata_load = 1'b1;
                    rdata_next = sram_dq_in;
                end
            end
            default: begin
                rdata_load = 1'b0;
            end
        endcase
    end

    // Read access counter: armed on entry to RD_ACC, counts down to the capture cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt <= '0;
        end else if (rd_cnt_load) begin
            rd_cnt <= RD_START;
        end else if (state == MAIN_RD_ACC && rd_cnt != '0) begin
            rd_cnt <= rd_cnt - 1'b1;
        end
    end

    // Read data register, held through DONE and until the next read completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dev_mem_data_in <= '0;
        end else if (rdata_load) begin
            dev_mem_data_in <= rdata_next;
        end
    end

    // Pin mux: the drain owns the pins when active, otherwise a read access, otherwise idle
    always_comb begin
        pin_strobe  = STROBE_IDLE;
        sram_addr   = '0;
        sram_dq_out = '0;
        if (drain_active) begin
            pin_strobe  = drain_strobe;
            sram_addr   = drain_addr;
            sram_dq_out = drain_data;
        end else if (state == MAIN_RD_ACC) begin
            pin_strobe  = STROBE_READ;
            sram_addr   = req_word;
        end
    end

    assign sram_ce_n    = pin_strobe.ce_n;
    assign sram_oe_n    = pin_strobe.oe_n;
    assign sram_we_n    = pin_strobe.we_n;
    assign sram_dq_oe   = pin_strobe.dq_oe;
    assign dev_mem_busy = (state != MAIN_DONE);

endmodule

// File: tb/tb_phy_mem_ctrl.sv
// Directed bench for phy_mem_ctrl with a simple synchronous SRAM model.
// Requests are presented in the DONE cycle of the previous access, so the
// following IDLE cycle is cycle 0 of the new one; an out-of-range read is
// used as an idle filler request between tests.
module tb_phy_mem_ctrl;

    localparam int ADDR_W   = 20;
    localparam int RD_WAIT  = 1;
    localparam int WR_PULSE = 1;
    localparam logic [31:0] PARK_ADDR = 32'hFFFF_FFFC;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       dev_mem_addr;
    logic [31:0]       dev_mem_data_out;
    logic              dev_mem_is_write;
    logic [31:0]       dev_mem_data_in;
    logic              dev_mem_busy;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_dq_in;
    logic [31:0]       sram_dq_out;
    logic              sram_dq_oe;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    phy_mem_ctrl #(
        .ADDR_W   (ADDR_W),
        .RD_WAIT  (RD_WAIT),
        .WR_PULSE (WR_PULSE)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .dev_mem_addr     (dev_mem_addr),
        .dev_mem_data_out (dev_mem_data_out),
        .dev_mem_is_write (dev_mem_is_write),
        .dev_mem_data_in  (dev_mem_data_in),
        .dev_mem_busy     (dev_mem_busy),
        .sram_addr        (sram_addr),
        .sram_dq_in       (sram_dq_in),
        .sram_dq_out      (sram_dq_out),
        .sram_dq_oe       (sram_dq_oe),
        .sram_ce_n        (sram_ce_n),
        .sram_oe_n        (sram_oe_n),
        .sram_we_n        (sram_we_n)
    );

    // SRAM model: write on a clock edge while ce_n/we_n are low, preload port for setup
    logic [31:0] mem [0:255];
    logic        preloadEn = 1'b0;
    logic [7:0]  preloadIdx = 8'd0;
    logic [31:0] preloadData = 32'd0;
    wire         unusedAddrHi = ^sram_addr[ADDR_W-1:8];

    always @(posedge clk) begin
        if (preloadEn) mem[preloadIdx] <= preloadData;
        else if (!sram_ce_n && !sram_we_n) mem[sram_addr[7:0]] <= sram_dq_out;
    end
    assign sram_dq_in = mem[sram_addr[7:0]];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Pin monitor: strobe counters plus dq_oe setup/hold around every we_n pulse
    int          oeLowCnt = 0;
    int          ceLowCnt = 0;
    int          weLowCnt = 0;
    int          dqOeCnt  = 0;
    logic [19:0] lastWeAddr = '0;
    logic        prevWeN  = 1'b1;
    logic        prevDqOe = 1'b0;
    bit          monEn    = 1'b0;

    always @(negedge clk) begin
        if (monEn) begin
            if (!sram_oe_n) oeLowCnt++;
            if (!sram_ce_n) ceLowCnt++;
            if (sram_dq_oe) dqOeCnt++;
            if (!sram_we_n) begin
                weLowCnt++;
                lastWeAddr = sram_addr;
            end
            if (!sram_we_n && prevWeN) checkOutput("dq_oe setup before we_n", 32'(prevDqOe), 32'd1);
            if (sram_we_n && !prevWeN) checkOutput("dq_oe hold after we_n", 32'(sram_dq_oe), 32'd1);
            prevWeN  = sram_we_n;
            prevDqOe = sram_dq_oe;
        end else begin
            prevWeN  = 1'b1;
            prevDqOe = 1'b0;
        end
    end

    // Wait (bounded) for the next negedge that shows busy=0
    task automatic waitDone(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (!dev_mem_busy) got = 1'b1;
        end
        checkOutput(tag, 32'(got), 32'd1);
    endtask

    // Present the idle filler request and let it complete n times
    task automatic park(input int n);
        dev_mem_addr     = PARK_ADDR;
        dev_mem_is_write = 1'b0;
        dev_mem_data_out = 32'd0;
        for (int k = 0; k < n; k++) waitDone("park completes");
    endtask

    // One access, entered at the negedge of a DONE cycle; lat = cycles from cycle 0 to busy=0
    task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [31:0] d,
                                 output int lat, output logic [31:0] rdata);
        bit done;
        dev_mem_addr     = a;
        dev_mem_is_write = w;
        dev_mem_data_out = d;
        lat   = 0;
        rdata = 32'd0;
        done  = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 40 && !done; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!dev_mem_busy) begin
                done  = 1'b1;
                lat   = i;
                rdata = dev_mem_data_in;
            end
        end
        checkOutput("access completes", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        int          oe0, ce0, we0, dq0;
        bit          seen;

        rst              = 1'b0;
        dev_mem_addr     = PARK_ADDR;
        dev_mem_is_write = 1'b0;
        dev_mem_data_out = 32'd0;

        // Preload SRAM while reset is held
        @(posedge clk); #1;
        preloadEn = 1'b1; preloadIdx = 8'd5; preloadData = 32'h1234_5678;
        @(posedge clk); #1;
        preloadIdx = 8'd3; preloadData = 32'hDEAD_0003;
        @(posedge clk); #1;
        preloadEn = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("reset busy",     32'(dev_mem_busy), 32'd1);
        checkOutput("reset ce_n",     32'(sram_ce_n),    32'd1);
        checkOutput("reset oe_n",     32'(sram_oe_n),    32'd1);
        checkOutput("reset we_n",     32'(sram_we_n),    32'd1);
        checkOutput("reset dq_oe",    32'(sram_dq_oe),   32'd0);
        checkOutput("reset data_in",  dev_mem_data_in,   32'd0);
        checkOutput("reset sram_addr", 32'(sram_addr),   32'd0);
        checkOutput("reset dq_out",   sram_dq_out,       32'd0);

        rst   = 1'b1;
        monEn = 1'b1;
        waitDone("first filler completes");

        // SRAM read of word 5
        oe0 = oeLowCnt;
        applyStimulus(32'h0000_0014, 1'b0, 32'd0, lat, rd);
        checkOutput("sram read latency", 32'(lat), 32'(RD_WAIT + 2));
        checkOutput("sram read data", rd, 32'h1234_5678);
        checkOutput("sram read oe_n cycles", 32'(oeLowCnt - oe0), 32'(RD_WAIT + 1));

        // Posted write then forwarded read of the same word
        we0 = weLowCnt;
        applyStimulus(32'h0000_0020, 1'b1, 32'hCAFE_BABE, lat, rd);
        checkOutput("posted write latency", 32'(lat), 32'd1);
        applyStimulus(32'h0000_0020, 1'b0, 32'd0, lat, rd);
        checkOutput("forward read latency", 32'(lat), 32'd1);
        checkOutput("forward read data", rd, 32'hCAFE_BABE);
        park(4);
        checkOutput("drain we_n cycles", 32'(weLowCnt - we0), 32'(WR_PULSE));
        checkOutput("drain sram_addr", 32'(lastWeAddr), 32'd8);
        checkOutput("sram word 8", mem[8], 32'hCAFE_BABE);
        applyStimulus(32'h0000_0020, 1'b0, 32'd0, lat, rd);
        checkOutput("readback latency", 32'(lat), 32'(RD_WAIT + 2));
        checkOutput("readback data", rd, 32'hCAFE_BABE);

        // Back-to-back writes: second one waits for the first drain
        we0 = weLowCnt;
        dq0 = dqOeCnt;
        applyStimulus(32'h0000_0000, 1'b1, 32'h1111_2222, lat, rd);
        checkOutput("b2b first latency", 32'(lat), 32'd1);
        applyStimulus(32'h0000_0004, 1'b1, 32'h3333_4444, lat, rd);
        checkOutput("b2b second latency", 32'(lat), 32'(WR_PULSE + 3));
        park(4);
        checkOutput("sram word 0", mem[0], 32'h1111_2222);
        checkOutput("sram word 1", mem[1], 32'h3333_4444);
        checkOutput("b2b we_n cycles", 32'(weLowCnt - we0), 32'(2 * WR_PULSE));
        checkOutput("b2b dq_oe cycles", 32'(dqOeCnt - dq0), 32'(2 * (WR_PULSE + 2)));

        // Out-of-range read and write
        oe0 = oeLowCnt;
        ce0 = ceLowCnt;
        we0 = weLowCnt;
        applyStimulus(32'h0100_0000, 1'b0, 32'd0, lat, rd);
        checkOutput("oor read latency", 32'(lat), 32'd1);
        checkOutput("oor read data", rd, 32'd0);
        applyStimulus(32'h0100_0000, 1'b1, 32'h5555_AAAA, lat, rd);
        checkOutput("oor write latency", 32'(lat), 32'd1);
        park(3);
        checkOutput("oor oe_n untouched", 32'(oeLowCnt - oe0), 32'd0);
        checkOutput("oor ce_n untouched", 32'(ceLowCnt - ce0), 32'd0);
        checkOutput("oor we_n untouched", 32'(weLowCnt - we0), 32'd0);

        // Reset during the we_n pulse aborts the drain
        monEn = 1'b0;
        applyStimulus(32'h0000_000C, 1'b1, 32'hBEEF_0003, lat, rd);
        checkOutput("abort write latency", 32'(lat), 32'd1);
        dev_mem_addr     = PARK_ADDR;
        dev_mem_is_write = 1'b0;
        dev_mem_data_out = 32'd0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (!sram_we_n) seen = 1'b1;
        end
        checkOutput("we_n pulse reached", 32'(seen), 32'd1);
        #1 rst = 1'b0;
        #1;
        checkOutput("async reset we_n", 32'(sram_we_n),  32'd1);
        checkOutput("async reset ce_n", 32'(sram_ce_n),  32'd1);
        checkOutput("async reset dq_oe", 32'(sram_dq_oe), 32'd0);
        checkOutput("async reset busy", 32'(dev_mem_busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        waitDone("filler after reset");
        monEn = 1'b1;
        applyStimulus(32'h0000_000C, 1'b0, 32'd0, lat, rd);
        checkOutput("post-abort read latency", 32'(lat), 32'(RD_WAIT + 2));
        checkOutput("post-abort read data", rd, 32'hDEAD_0003);
        checkOutput("sram word 3", mem[3], 32'hDEAD_0003);
        park(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
